// File: rtl/adc_mcp3202_reader.sv
// Purpose: SPI mode-0,0 master that alternately converts MCP3202 channels 0/1 into CH0/CH1 (optional 4-sample averaging when ADC_AVG_EN is defined).
// Latency: one conversion every 35*CLK_DIV + HOLD_CYC + 1 clk25 cycles; sample_valid pulses HOLD_CYC+1 cycles after adc_cs_n rises.
// Backpressure: none; CH0/CH1 are overwrite-latest registers and sample_valid is a single-cycle strobe.
module adc_mcp3202_reader #(
    parameter int CLK_DIV  = 16,
    parameter int HOLD_CYC = 16
) (
    input  logic        clk25,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        adc_miso,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_mosi,
    output logic [11:0] CH0,
    output logic [11:0] CH1,
    output logic        sample_valid,
    output logic        sample_ch
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_SETUP  = 2'd1;
    localparam logic [1:0]  ST_SHIFT  = 2'd2;
    localparam logic [1:0]  ST_HOLD   = 2'd3;

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYC - 1);
    // 17 SCLK periods = 34 half periods, indexed 0..33
    localparam logic [5:0]  LAST_HALF = 6'd33;
    localparam logic [11:0] CENTRE    = 12'd2048;

    logic [1:0]  state;
    logic [15:0] cnt;
    logic [5:0]  half;
    logic        miso_meta;
    logic        miso_sync;
    logic [17:0] shreg;
    logic        frame_ch;
    logic        next_ch;
    logic        commit_pend;
    logic        hold_done;
    logic        null_bit;
    logic [11:0] result;
    logic        shreg_unused;

    // After 17 rising edges the null bit sits at [12] and B11..B0 at [11:0];
    // the upper bits hold the command-phase garbage and are never consumed.
    assign hold_done    = (state == ST_HOLD) && (cnt == HOLD_LAST);
    assign null_bit     = shreg[12];
    assign result       = shreg[11:0];
    assign shreg_unused = ^shreg[17:13];

    // Two-flop synchronizer for the ADC data line
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
        end else begin
            miso_meta <= adc_miso;
            miso_sync <= miso_meta;
        end
    end

    // Frame sequencer: drives CS/SCLK/MOSI and shifts MISO in on each SCLK rise
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            half     <= '0;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b0;
            adc_mosi <= 1'b0;
            shreg    <= '0;
            frame_ch <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state    <= ST_SETUP;
                        cnt      <= '0;
                        adc_cs_n <= 1'b0;
                        adc_sclk <= 1'b0;
                        adc_mosi <= 1'b1;      // start bit, sampled on rise 1
                        frame_ch <= next_ch;
                    end
                end
                ST_SETUP: begin
                    if (cnt == DIV_LAST) begin
                        state <= ST_SHIFT;
                        cnt   <= '0;
                        half  <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == DIV_LAST) begin
                        cnt  <= '0;
                        half <= half + 6'd1;
                        if (!half[0]) begin
                            // end of low half: rising edge, sample MISO
                            adc_sclk <= 1'b1;
                            shreg    <= {shreg[16:0], miso_sync};
                        end else begin
                            // end of high half: falling edge k = half[5:1]+1
                            adc_sclk <= 1'b0;
                            case (half[5:1])
                                5'd0:    adc_mosi <= 1'b1;      // SGL
                                5'd1:    adc_mosi <= frame_ch;  // ODD selects channel
                                5'd2:    adc_mosi <= 1'b1;      // MSBF
                                default: adc_mosi <= 1'b0;
                            endcase
                            if (half == LAST_HALF) begin
                                state    <= ST_HOLD;
                                adc_cs_n <= 1'b1;
                                adc_mosi <= 1'b0;
                            end
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    if (cnt == HOLD_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    // Accept a frame only when its null bit reads 0; a rejected frame retries the same channel
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            next_ch     <= 1'b0;
            commit_pend <= 1'b0;
        end else begin
            commit_pend <= hold_done && !null_bit;
            if (hold_done && !null_bit) begin
                next_ch <= ~next_ch;
            end
        end
    end

`ifdef ADC_AVG_EN
    logic [13:0] acc0;
    logic [13:0] acc1;
    logic [1:0]  acnt0;
    logic [1:0]  acnt1;
    logic [13:0] acc_sum;

    assign acc_sum = (frame_ch ? acc1 : acc0) + 14'(result);

    // Average four accepted samples per channel before publishing
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            CH0          <= CENTRE;
            CH1          <= CENTRE;
            sample_valid <= 1'b0;
            sample_ch    <= 1'b0;
            acc0         <= '0;
            acc1         <= '0;
            acnt0        <= '0;
            acnt1        <= '0;
        end else begin
            sample_valid <= 1'b0;
            if (commit_pend) begin
                if (!frame_ch) begin
                    if (acnt0 == 2'd3) begin
                        CH0          <= acc_sum[13:2];
                        acc0         <= '0;
                        acnt0        <= '0;
                        sample_valid <= 1'b1;
                        sample_ch    <= 1'b0;
                    end else begin
                        acc0  <= acc_sum;
                        acnt0 <= acnt0 + 2'd1;
                    end
                end else begin
                    if (acnt1 == 2'd3) begin
                        CH1          <= acc_sum[13:2];
                        acc1         <= '0;
                        acnt1        <= '0;
                        sample_valid <= 1'b1;
                        sample_ch    <= 1'b1;
                    end else begin
                        acc1  <= acc_sum;
                        acnt1 <= acnt1 + 2'd1;
                    end
                end
            end
        end
    end
`else
    // Publish every accepted sample straight into its channel register
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            CH0          <= CENTRE;
            CH1          <= CENTRE;
            sample_valid <= 1'b0;
            sample_ch    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (commit_pend) begin
                if (frame_ch) begin
                    CH1 <= result;
                end else begin
                    CH0 <= result;
                end
                sample_valid <= 1'b1;
                sample_ch    <= frame_ch;
            end
        end
    end
`endif

endmodule

// File: tb/tb_adc_mcp3202_reader.sv
// Purpose: directed self-checking bench for adc_mcp3202_reader with a behavioural MCP3202 model.
// Latency: checks the 577-cycle conversion period and commit pulse position per frame.
// Backpressure: not applicable; the DUT has no flow control.
module tb_adc_mcp3202_reader;

    localparam int CLK_DIV  = 16;
    localparam int HOLD_CYC = 16;
    localparam int PERIOD   = 577;   // 35*16 + 16 + 1

    logic        clk25 = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        adc_miso = 1'b0;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_mosi;
    logic [11:0] CH0;
    logic [11:0] CH1;
    logic        sample_valid;
    logic        sample_ch;

    int tests = 0;
    int fails = 0;

    // ADC model controls and frame record
    logic [11:0] ch0_val = '0;
    logic [11:0] ch1_val = '0;
    logic        null_err = 1'b0;
    logic [11:0] mdl_val = '0;
    int          rise_n = 0;
    logic [3:0]  cmd_sh = '0;
    logic [3:0]  last_cmd = '0;
    int          last_rises = 0;

    // Cycle monitor
    int   cyc = 0;
    int   fall_cyc = 0;
    int   fall_count = 0;
    int   pulse_cyc = 0;
    int   pulse_count = 0;
    logic prev_cs = 1'b1;
    logic last_sc = 1'b0;

    typedef struct {
        logic [11:0] ch0_val;
        logic [11:0] ch1_val;
        logic        null_err;
        logic [3:0]  exp_cmd;
        int          exp_pulse;
        logic        exp_sc;
        logic [11:0] exp_ch0;
        logic [11:0] exp_ch1;
    } vec_t;

    vec_t vecs [6];

    adc_mcp3202_reader #(.CLK_DIV(CLK_DIV), .HOLD_CYC(HOLD_CYC)) dut (
        .clk25        (clk25),
        .rst_n        (rst_n),
        .enable       (enable),
        .adc_miso     (adc_miso),
        .adc_cs_n     (adc_cs_n),
        .adc_sclk     (adc_sclk),
        .adc_mosi     (adc_mosi),
        .CH0          (CH0),
        .CH1          (CH1),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch)
    );

    always #20 clk25 = ~clk25;

    always @(posedge clk25) cyc++;

    // Record chip-select falls and commit pulses mid-cycle
    always @(negedge clk25) begin
        if (prev_cs === 1'b1 && adc_cs_n === 1'b0) begin
            fall_cyc = cyc;
            fall_count++;
        end
        prev_cs = adc_cs_n;
        if (sample_valid === 1'b1) begin
            pulse_cyc = cyc;
            pulse_count++;
            last_sc = sample_ch;
        end
    end

    // MCP3202: latch command bits on rises 1..4
    always @(posedge adc_sclk) begin
        if (adc_cs_n === 1'b0) begin
            rise_n++;
            if (rise_n <= 4) cmd_sh = {cmd_sh[2:0], adc_mosi};
        end
    end

    // MCP3202: null bit after fall 4, then B11..B0 after falls 5..16
    always @(negedge adc_sclk) begin
        if (adc_cs_n === 1'b0) begin
            if (rise_n == 4) begin
                adc_miso = null_err;
            end else if (rise_n >= 5 && rise_n <= 16) begin
                mdl_val  = cmd_sh[1] ? ch1_val : ch0_val;
                adc_miso = mdl_val[16 - rise_n];
            end else begin
                adc_miso = 1'b0;
            end
        end
    end

    always @(posedge adc_cs_n) begin
        last_rises = rise_n;
        last_cmd   = cmd_sh;
        rise_n     = 0;
        adc_miso   = 1'b0;
    end

    task automatic tick();
        @(negedge clk25);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic run_frame(output logic [3:0] cmd, output int rises, output int npulse, output int lat);
        int t;
        int start;
        int p0;
        t = 0;
        while (adc_cs_n !== 1'b0 && t < 2000) begin tick(); t++; end
        check("frame_start", 32'(adc_cs_n), 32'd0);
        start = fall_cyc;
        t = 0;
        while (adc_cs_n !== 1'b1 && t < 2000) begin tick(); t++; end
        check("frame_end", 32'(adc_cs_n), 32'd1);
        p0 = pulse_count;
        repeat (HOLD_CYC + 4) tick();
        cmd    = last_cmd;
        rises  = last_rises;
        npulse = pulse_count - p0;
        lat    = pulse_cyc - start;
    endtask

    initial begin
        #(50000 * 40);
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] cmd;
        int rises;
        int np;
        int lat;
        int t;
        int start;
        int f0;
        logic [11:0] avg_in [4];

        vecs[0] = '{12'hABC, 12'h123, 1'b0, 4'b1101, 1, 1'b0, 12'hABC, 12'h800};
        vecs[1] = '{12'hABC, 12'h123, 1'b0, 4'b1111, 1, 1'b1, 12'hABC, 12'h123};
        vecs[2] = '{12'h5A5, 12'h123, 1'b1, 4'b1101, 0, 1'b0, 12'hABC, 12'h123};
        vecs[3] = '{12'h555, 12'h321, 1'b0, 4'b1101, 1, 1'b0, 12'h555, 12'h123};
        vecs[4] = '{12'h555, 12'hFFF, 1'b0, 4'b1111, 1, 1'b1, 12'h555, 12'hFFF};
        vecs[5] = '{12'h000, 12'hFFF, 1'b0, 4'b1101, 1, 1'b0, 12'h000, 12'hFFF};
        avg_in  = '{12'd100, 12'd200, 12'd300, 12'd404};

        // Reset hold
        repeat (3) tick();
        check("rst_cs_n", 32'(adc_cs_n), 32'd1);
        check("rst_sclk", 32'(adc_sclk), 32'd0);
        check("rst_mosi", 32'(adc_mosi), 32'd0);
        check("rst_ch0", 32'(CH0), 32'd2048);
        check("rst_ch1", 32'(CH1), 32'd2048);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_sc", 32'(sample_ch), 32'd0);
        rst_n = 1'b1;
        tick();
        enable = 1'b1;

`ifndef ADC_AVG_EN
        // Back-to-back frames from the vector table
        for (int i = 0; i < 6; i++) begin
            ch0_val  = vecs[i].ch0_val;
            ch1_val  = vecs[i].ch1_val;
            null_err = vecs[i].null_err;
            run_frame(cmd, rises, np, lat);
            check($sformatf("v%0d_cmd", i), 32'(cmd), 32'(vecs[i].exp_cmd));
            check($sformatf("v%0d_rises", i), 32'(rises), 32'd17);
            check($sformatf("v%0d_pulses", i), 32'(np), 32'(vecs[i].exp_pulse));
            if (vecs[i].exp_pulse != 0) begin
                check($sformatf("v%0d_latency", i), 32'(lat), 32'(PERIOD));
                check($sformatf("v%0d_sc", i), 32'(last_sc), 32'(vecs[i].exp_sc));
            end
            check($sformatf("v%0d_ch0", i), 32'(CH0), 32'(vecs[i].exp_ch0));
            check($sformatf("v%0d_ch1", i), 32'(CH1), 32'(vecs[i].exp_ch1));
        end
        null_err = 1'b0;

        // Enable drop 100 cycles into a ch1 frame
        ch1_val = 12'h2A5;
        t = 0;
        while (adc_cs_n !== 1'b0 && t < 2000) begin tick(); t++; end
        start = fall_cyc;
        while (cyc < start + 100) tick();
        enable = 1'b0;
        run_frame(cmd, rises, np, lat);
        check("drop_cmd", 32'(cmd), 32'b1111);
        check("drop_pulses", 32'(np), 32'd1);
        check("drop_latency", 32'(lat), 32'(PERIOD));
        check("drop_sc", 32'(last_sc), 32'd1);
        check("drop_ch1", 32'(CH1), 32'h2A5);
        f0 = fall_count;
        repeat (700) tick();
        check("drop_idle_falls", 32'(fall_count - f0), 32'd0);
        check("drop_idle_cs", 32'(adc_cs_n), 32'd1);
        enable  = 1'b1;
        ch0_val = 12'h7E7;
        run_frame(cmd, rises, np, lat);
        check("reen_cmd", 32'(cmd), 32'b1101);
        check("reen_pulses", 32'(np), 32'd1);
        check("reen_ch0", 32'(CH0), 32'h7E7);

        // Reset during SCLK high half of edge 9
        ch1_val = 12'h0F0;
        t = 0;
        while (adc_cs_n !== 1'b0 && t < 2000) begin tick(); t++; end
        t = 0;
        while (rise_n < 9 && t < 2000) begin tick(); t++; end
        check("mid_edge9", 32'(rise_n), 32'd9);
        rst_n = 1'b0;
        #1;
        check("mid_cs_n", 32'(adc_cs_n), 32'd1);
        check("mid_sclk", 32'(adc_sclk), 32'd0);
        check("mid_mosi", 32'(adc_mosi), 32'd0);
        check("mid_ch0", 32'(CH0), 32'd2048);
        check("mid_ch1", 32'(CH1), 32'd2048);
        check("mid_valid", 32'(sample_valid), 32'd0);
        repeat (3) tick();
        rst_n   = 1'b1;
        ch0_val = 12'h3C3;
        run_frame(cmd, rises, np, lat);
        check("post_rst_cmd", 32'(cmd), 32'b1101);
        check("post_rst_pulses", 32'(np), 32'd1);
        check("post_rst_sc", 32'(last_sc), 32'd0);
        check("post_rst_ch0", 32'(CH0), 32'h3C3);
        check("post_rst_ch1", 32'(CH1), 32'd2048);
`else
        // Four ch0 samples 100,200,300,404 average to 251; ch1 holds 1000
        ch1_val = 12'd1000;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) ch0_val = avg_in[i / 2];
            run_frame(cmd, rises, np, lat);
            check($sformatf("avg%0d_cmd", i), 32'(cmd), (i % 2 == 0) ? 32'b1101 : 32'b1111);
            check($sformatf("avg%0d_pulses", i), 32'(np), (i >= 6) ? 32'd1 : 32'd0);
            if (np == 1) check($sformatf("avg%0d_sc", i), 32'(last_sc), 32'(i % 2));
            check($sformatf("avg%0d_ch0", i), 32'(CH0), (i >= 6) ? 32'd251 : 32'd2048);
            check($sformatf("avg%0d_ch1", i), 32'(CH1), (i == 7) ? 32'd1000 : 32'd2048);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
